// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, complex sample type and index bit-reversal.
// Also consumed by the output sorter.
package fft_pkg;
  localparam int FFT_N     = 32;
  localparam int FFT_LOG2N = 5;
  localparam int FFT_DW    = 16;

  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } sample_t;

  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] idx);
    logic [FFT_LOG2N-1:0] r;
    for (int b = 0; b < FFT_LOG2N; b++) r[b] = idx[FFT_LOG2N-1-b];
    return r;
  endfunction
endpackage

// File: rtl/fft_frame_bank.sv
// N-entry complex register bank: whole-frame parallel write, single combinational read port.
module fft_frame_bank #(
  parameter int N     = 32,
  parameter int LOG2N = 5,
  parameter int DW    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_we,
  input  logic [N*DW-1:0]         i_data_r,
  input  logic [N*DW-1:0]         i_data_i,
  input  logic [LOG2N-1:0]        i_raddr,
  output logic signed [DW-1:0]    o_re,
  output logic signed [DW-1:0]    o_im
);
  logic signed [DW-1:0] r_re [N];
  logic signed [DW-1:0] r_im [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
    end else if (i_we) begin
      for (int i = 0; i < N; i++) begin
        r_re[i] <= i_data_r[i*DW +: DW];
        r_im[i] <= i_data_i[i*DW +: DW];
      end
    end
  end

  assign o_re = r_re[i_raddr];
  assign o_im = r_im[i_raddr];
endmodule

// File: rtl/fft_frame_serializer.sv
// Ping-pong frame serializer: parallel complex frame in, one sample per cycle out,
// natural or bit-reversed order, gapless across back-to-back frames.
module fft_frame_serializer
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N,
  parameter int DW    = FFT_DW,
  parameter int ORDER = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  input  logic [N*DW-1:0]      frame_r,
  input  logic [N*DW-1:0]      frame_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic                 out_first,
  output logic                 out_last
);
  logic [1:0]           r_occ;
  logic                 r_wr_sel;
  logic                 r_rd_sel;
  logic [LOG2N-1:0]     r_step;

  logic                 w_acc;
  logic                 w_xfer;
  logic                 w_rel;
  logic [LOG2N-1:0]     w_raddr;
  logic signed [DW-1:0] w_re [2];
  logic signed [DW-1:0] w_im [2];
  sample_t              w_smp;

  assign frame_ready = (r_occ != 2'd2);
  assign out_valid   = (r_occ != 2'd0);
  assign w_acc       = frame_valid & frame_ready;
  assign w_xfer      = out_valid & out_ready;
  assign out_first   = out_valid & (r_step == '0);
  assign out_last    = out_valid & (r_step == LOG2N'(N-1));
  assign w_rel       = w_xfer & out_last;

  generate
    if (ORDER != 0) begin : g_rev
      assign w_raddr = bitrev(r_step);
    end else begin : g_nat
      assign w_raddr = r_step;
    end
  endgenerate

  // Accept only ever targets bank[wr_sel]; wr_sel != rd_sel whenever a frame is pending.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(.N(N), .LOG2N(LOG2N), .DW(DW)) u_bank (
      .clk      (clk),
      .rst      (rst),
      .i_we     (w_acc && (r_wr_sel == 1'(b))),
      .i_data_r (frame_r),
      .i_data_i (frame_i),
      .i_raddr  (w_raddr),
      .o_re     (w_re[b]),
      .o_im     (w_im[b])
    );
  end

  assign w_smp.re = w_re[r_rd_sel];
  assign w_smp.im = w_im[r_rd_sel];
  assign out_r    = out_valid ? w_smp.re : '0;
  assign out_i    = out_valid ? w_smp.im : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ    <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_step   <= '0;
    end else begin
      if (w_acc)  r_wr_sel <= ~r_wr_sel;
      if (w_rel)  r_rd_sel <= ~r_rd_sel;
      if (w_xfer) r_step   <= r_step + 1'b1;
      r_occ <= r_occ + {1'b0, w_acc} - {1'b0, w_rel};
    end
  end
endmodule
